// File: rtl/bias_fetch_scheduler_pkg.sv
// bias_fetch_scheduler_pkg: shared beat geometry, burst defaults and FSM states for the bias fetch path.
package bias_fetch_scheduler_pkg;
   localparam int BYTES_PER_BEAT  = 16;
   localparam int BIASES_PER_BEAT = 8;
   localparam int BURST_LEN_DEF   = 64;
   localparam int LEN_W_DEF       = 8;
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_DATA, S_DONE} state_e;
endpackage

// File: rtl/bias_fetch_scheduler_splitter.sv
// bias_burst_splitter: next burst length (capped at BURST_LEN) and post-burst address advance.
module bias_burst_splitter
   import bias_fetch_scheduler_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int REM_W     = 14,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int LEN_W     = LEN_W_DEF
) (
   input  logic [REM_W-1:0]  rem_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [LEN_W-1:0]  burst_len_o,
   output logic [ADDR_W-1:0] next_addr_o
);
   assign burst_len_o = (rem_i > REM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(rem_i);
   assign next_addr_o = addr_i + (ADDR_W'(len_i) << $clog2(BYTES_PER_BEAT));
endmodule

// File: rtl/bias_fetch_scheduler.sv
// bias_fetch_scheduler: issues almost-full-gated DDR bursts for one layer of biases and forwards
// returned beats to the bias FIFO.
module bias_fetch_scheduler
   import bias_fetch_scheduler_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int CNT_W     = 16,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int LEN_W     = LEN_W_DEF
) (
   input  logic              system_clk,
   input  logic              rst,
   input  logic              i_layer_start,
   input  logic [ADDR_W-1:0] i_bias_base_addr,
   input  logic [CNT_W-1:0]  i_bias_num,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [LEN_W-1:0]  o_rd_len,
   input  logic              i_rd_ack,
   input  logic              i_rd_valid,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_fifo_wren,
   output logic [DATA_W-1:0] o_fifo_wrdata,
   input  logic              i_fifo_full,
   input  logic              i_fifo_almost_full
);
   localparam int REM_W = CNT_W - 2;
   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q, rd_addr_q, next_addr;
   logic [REM_W-1:0]    rem_q, beats_total;
   logic [LEN_W-1:0]    cnt_q, rd_len_q, burst_len;
   logic [DATA_W-1:0]   wrdata_q;
   logic                busy_q, done_q, err_q, err_d, rd_req_q, wren_q, accept, in_data;
   // the cycle showing the done pulse is already IDLE, so a start there must be refused
   assign accept      = state_q == S_IDLE && !done_q && i_layer_start;
   assign in_data     = state_q == S_DATA;
   assign beats_total = REM_W'(({1'b0, i_bias_num} + (CNT_W+1)'(BIASES_PER_BEAT - 1)) >> $clog2(BIASES_PER_BEAT));
   assign err_d       = (accept ? 1'b0 : err_q) | (i_rd_valid && (!in_data || i_fifo_full));
   bias_burst_splitter #(.ADDR_W(ADDR_W), .REM_W(REM_W), .BURST_LEN(BURST_LEN), .LEN_W(LEN_W)) u_split (
      .rem_i(rem_q), .addr_i(addr_q), .len_i(rd_len_q), .burst_len_o(burst_len), .next_addr_o(next_addr)
   );
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rd_addr_q <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         rd_len_q  <= '0;
         wrdata_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_req_q  <= 1'b0;
         wren_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= err_d;
         wren_q <= i_rd_valid && in_data;
         if (i_rd_valid && in_data) wrdata_q <= i_rd_data;
         case (state_q)
            S_IDLE: if (accept) begin
               addr_q  <= i_bias_base_addr;
               rem_q   <= beats_total;
               busy_q  <= 1'b1;
               state_q <= (beats_total == '0) ? S_DONE : S_CHECK;
            end
            S_CHECK: if (!i_fifo_almost_full) begin
               rd_addr_q <= addr_q;
               rd_len_q  <= burst_len;
               rd_req_q  <= 1'b1;
               state_q   <= S_REQ;
            end
            S_REQ: if (i_rd_ack) begin
               rd_req_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= S_DATA;
            end
            S_DATA: if (i_rd_valid) begin
               cnt_q <= cnt_q + LEN_W'(1);
               if (cnt_q + LEN_W'(1) == rd_len_q) begin
                  addr_q  <= next_addr;
                  rem_q   <= rem_q - REM_W'(rd_len_q);
                  state_q <= (rem_q == REM_W'(rd_len_q)) ? S_DONE : S_CHECK;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_err         = err_q;
   assign o_rd_req      = rd_req_q;
   assign o_rd_addr     = rd_addr_q;
   assign o_rd_len      = rd_len_q;
   assign o_fifo_wren   = wren_q;
   assign o_fifo_wrdata = wrdata_q;
endmodule

// File: tb/tb_bias_fetch_scheduler.sv
// tb_bias_fetch_scheduler: randomized DDR responder checked against a burst-list reference model.
module tb_bias_fetch_scheduler;
   logic          system_clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_layer_start = 1'b0;
   logic [31:0]   i_bias_base_addr = '0;
   logic [15:0]   i_bias_num = '0;
   logic          o_busy, o_done, o_err, o_rd_req, o_fifo_wren;
   logic [31:0]   o_rd_addr;
   logic [7:0]    o_rd_len;
   logic          i_rd_ack = 1'b0, i_rd_valid = 1'b0, i_fifo_full = 1'b0, i_fifo_almost_full = 1'b0;
   logic [127:0]  i_rd_data = '0, o_fifo_wrdata;
   int            n_chk = 0, n_err = 0, wr_cnt = 0;
   logic [127:0]  exp_q[$];

   bias_fetch_scheduler dut (
      .system_clk(system_clk), .rst(rst), .i_layer_start(i_layer_start),
      .i_bias_base_addr(i_bias_base_addr), .i_bias_num(i_bias_num),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len), .i_rd_ack(i_rd_ack),
      .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
      .o_fifo_wren(o_fifo_wren), .o_fifo_wrdata(o_fifo_wrdata),
      .i_fifo_full(i_fifo_full), .i_fifo_almost_full(i_fifo_almost_full)
   );

   always #5 system_clk = ~system_clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge system_clk) begin
      if (!rst && o_fifo_wren) begin
         wr_cnt++;
         if (exp_q.size() == 0) chk("wr_extra", 128'd1, 128'd0);
         else chk("wr_data", o_fifo_wrdata, exp_q.pop_front());
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (o_rd_req) begin
            ok = 1'b1;
            return;
         end
         @(negedge system_clk);
      end
      chk("req_timeout", 128'd0, 128'd1);
   endtask

   task automatic send_beat(input logic [127:0] d, input logic full);
      i_rd_valid = 1'b1;
      i_rd_data = d;
      i_fifo_full = full;
      exp_q.push_back(d);
      @(negedge system_clk);
      i_rd_valid = 1'b0;
      i_fifo_full = 1'b0;
      chk("wren_lat", o_fifo_wren, 128'd1);
   endtask

   task automatic pulse_start(input logic [31:0] base, input int num);
      i_bias_base_addr = base;
      i_bias_num = 16'(num);
      i_layer_start = 1'b1;
      @(negedge system_clk);
      i_layer_start = 1'b0;
   endtask

   // mode: 0 plain, 1 almost-full held after first burst, 2 stray start mid-burst, 3 beat while FIFO full
   task automatic run_layer(input logic [31:0] base, input int num, input int mode);
      logic [31:0] ea[$];
      int          el[$];
      int          rem, tot, wr0, l;
      logic [31:0] a;
      bit          ok, seen;
      rem = (num + 7) / 8;
      tot = rem;
      a = base;
      while (rem > 0) begin
         l = rem > 64 ? 64 : rem;
         ea.push_back(a);
         el.push_back(l);
         a += 32'(l * 16);
         rem -= l;
      end
      wr0 = wr_cnt;
      pulse_start(base, num);
      chk("busy", o_busy, 128'd1);
      chk("err_clr", o_err, 128'd0);
      for (int k = 0; k < ea.size(); k++) begin
         wait_req((mode == 1 && k == 1) ? 2 : 200, ok);
         if (!ok) return;
         chk("rd_addr", o_rd_addr, ea[k]);
         chk("rd_len", o_rd_len, 128'(el[k]));
         repeat ($urandom_range(0, 3)) @(negedge system_clk);
         chk("req_held", o_rd_req, 128'd1);
         i_rd_ack = 1'b1;
         @(negedge system_clk);
         i_rd_ack = 1'b0;
         chk("req_drop", o_rd_req, 128'd0);
         for (int b = 0; b < el[k]; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge system_clk);
            if (mode == 2 && k == 0 && b == 1) pulse_start(32'h0BAD_0000, 40);
            send_beat(rnd128(), mode == 3 && k == 0 && b == 0);
         end
         if (mode == 1 && k == 0) begin
            i_fifo_almost_full = 1'b1;
            seen = 1'b0;
            repeat (50) begin
               @(negedge system_clk);
               if (o_rd_req) seen = 1'b1;
            end
            chk("af_gate", 128'(seen), 128'd0);
            i_fifo_almost_full = 1'b0;
         end
      end
      for (int i = 0; i < 20 && !o_done; i++) @(negedge system_clk);
      chk("done", o_done, 128'd1);
      chk("busy_at_done", o_busy, 128'd0);
      chk("wr_count", 128'(wr_cnt - wr0), 128'(tot));
      chk("err", o_err, 128'(mode == 3));
      @(negedge system_clk);
      chk("done_pulse", o_done, 128'd0);
   endtask

   initial begin
      bit ok;
      @(negedge system_clk);
      chk("rst_outs", {o_busy, o_done, o_err, o_rd_req, o_rd_addr, o_rd_len, o_fifo_wren}, 128'd0);
      rst = 1'b0;
      @(negedge system_clk);
      chk("idle_outs", {o_busy, o_done, o_err, o_rd_req, o_fifo_wren}, 128'd0);
      pulse_start(32'h0000_5000, 0);
      chk("z_busy", o_busy, 128'd1);
      chk("z_done0", o_done, 128'd0);
      @(negedge system_clk);
      chk("z_done", o_done, 128'd1);
      chk("z_busy_off", o_busy, 128'd0);
      chk("z_req", o_rd_req, 128'd0);
      i_layer_start = 1'b1;
      @(negedge system_clk);
      i_layer_start = 1'b0;
      chk("start_on_done", o_busy, 128'd0);
      run_layer(32'h0000_1000, 8, 0);
      run_layer(32'h0000_2000, 1000, 0);
      run_layer(32'h0000_2000, 1000, 1);
      run_layer(32'h0000_8000, 700, 2);
      run_layer(32'hFFFF_FC00, 1000, 0);
      repeat (4) run_layer($urandom, $urandom_range(1, 700), 0);
      i_rd_valid = 1'b1;
      i_rd_data = rnd128();
      @(negedge system_clk);
      i_rd_valid = 1'b0;
      chk("idle_beat_err", o_err, 128'd1);
      chk("idle_beat_nowr", o_fifo_wren, 128'd0);
      repeat (5) @(negedge system_clk);
      chk("err_sticky", o_err, 128'd1);
      run_layer(32'h0000_4000, 100, 3);
      pulse_start(32'h0000_3000, 512);
      wait_req(200, ok);
      if (ok) begin
         i_rd_ack = 1'b1;
         @(negedge system_clk);
         i_rd_ack = 1'b0;
         repeat (3) send_beat(rnd128(), 1'b0);
      end
      rst = 1'b1;
      #1;
      chk("rst_mid", {o_busy, o_done, o_err, o_rd_req, o_rd_addr, o_rd_len, o_fifo_wren, o_fifo_wrdata[31:0]}, 128'd0);
      @(negedge system_clk);
      rst = 1'b0;
      exp_q.delete();
      i_rd_valid = 1'b1;
      @(negedge system_clk);
      i_rd_valid = 1'b0;
      chk("late_beat_err", o_err, 128'd1);
      chk("late_beat_nowr", o_fifo_wren, 128'd0);
      run_layer(32'h0000_6000, 64, 0);
      chk("exp_drained", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
